// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the completer register block, its wait
// counter and the requester-side code.
//   - apb_state_e : completer FSM state encoding (IDLE=0, SETUP=1, ACCESS=2)
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - ERR_ALIGN / ERR_RANGE / ERR_RO : bit positions in an apb_err_t
//     error-reason vector; a transfer errors when any reason bit is set.
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Error-reason bit positions
    localparam int ERR_ALIGN = 0;  // paddr[1:0] != 0
    localparam int ERR_RANGE = 1;  // word index beyond the register bank
    localparam int ERR_RO    = 2;  // write to the read-only ID register
    localparam int ERR_NUM   = 3;

    typedef logic [ERR_NUM-1:0] apb_err_t;

endpackage

// File: rtl/apb_wait_ctr.sv
// -----------------------------------------------------------------------------
// apb_wait_ctr
// Loadable down-counter with a zero flag. The completer uses it to insert
// wait states; the requester side can reuse it as a timeout counter.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module apb_wait_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            // Guarded so the count never wraps below zero
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regs.sv
// -----------------------------------------------------------------------------
// apb_slave_regs
// APB completer with a small word-aligned register bank and a programmable
// number of wait states per access.
//   Register 0           : read-only, returns ID_VALUE
//   Registers 1..N-1     : full-width read/write, reset to 0
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   psel       : completer select
//   penable    : access-phase indicator
//   pwrite     : 1 = write, 0 = read (sampled in the setup phase)
//   paddr      : byte address (sampled in the setup phase)
//   pwdata     : write data (sampled in the setup phase)
//   pready     : access complete
//   prdata     : read data, non-zero only while pready=1 on a good read
//   pslverr    : error response, only while pready=1
//   proto_err  : sticky flag for illegal phase sequences, cleared by rst
//
// Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
// access cycles (psel=1, penable=1). The access phase ends on the first
// access cycle with pready=1; the write commits and read data is presented
// in that same cycle. pready rises in access cycle WAIT_CYCLES+1.
//
// FSM timing: the setup phase is observed while state_q is IDLE, so state_q
// is SETUP during the first access cycle and ACCESS for any later access
// cycles. SETUP therefore already counts as an access cycle, which keeps a
// full transfer at WAIT_CYCLES+2 cycles and lets WAIT_CYCLES=0 complete in
// the first access cycle. state_q is the observable FSM state.
// -----------------------------------------------------------------------------
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic              proto_err
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WORD_W = ADDR_W - 2;
    localparam int CNT_W  = $clog2(WAIT_CYCLES + 2);

    localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);
    localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

    apb_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    apb_err_t          err_q;
    logic              proto_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              xfer_on;
    logic              setup_seen;
    logic              in_access;
    logic              ctr_dec;
    logic              ctr_zero;
    logic              commit;
    logic              wr_en;
    apb_err_t          err_in;
    logic [DATA_W-1:0] rd_val;

    assign xfer_on    = psel && penable;
    assign in_access  = (state_q == SETUP) || (state_q == ACCESS);

    // A setup cycle is accepted from IDLE, and re-accepted while in SETUP
    // if the requester repeats it.
    assign setup_seen = psel && !penable &&
                        ((state_q == IDLE) || (state_q == SETUP));

    // Error reasons decoded from the setup-phase address; only the latched
    // copy is used afterwards.
    always_comb begin
        err_in            = '0;
        err_in[ERR_ALIGN] = (paddr[1:0] != 2'b00);
        err_in[ERR_RANGE] = (paddr[ADDR_W-1:2] >= NUM_REGS_W);
        err_in[ERR_RO]    = pwrite && (paddr[ADDR_W-1:2] == '0);
    end

    apb_wait_ctr #(
        .CNT_W (CNT_W)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (setup_seen),
        .load_val_i (WAIT_LOAD),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    assign ctr_dec = in_access && xfer_on && !ctr_zero;

    // In SETUP the first access cycle is only real once penable is high;
    // in ACCESS pready follows the counter alone.
    always_comb begin
        pready = 1'b0;
        case (state_q)
            SETUP:   pready = xfer_on && ctr_zero;
            ACCESS:  pready = ctr_zero;
            default: pready = 1'b0;
        endcase
    end

    assign commit = pready && xfer_on;
    assign wr_en  = commit && write_q && (err_q == '0);

    assign rd_val    = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
    // Any error (including a misaligned in-range read) returns zero data
    assign prdata    = (pready && !write_q && (err_q == '0)) ? rd_val : '0;
    assign pslverr   = pready && (err_q != '0);
    assign proto_err = proto_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= '0;
            proto_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (penable) begin
                        // Access phase without a preceding setup
                        proto_q <= 1'b1;
                    end else if (psel) begin
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (!psel) begin
                        // Dropped before any access cycle: silent abort
                        state_q <= IDLE;
                    end else if (!penable) begin
                        state_q <= SETUP;
                    end else if (ctr_zero) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!xfer_on) begin
                        // Requester left the access phase before completion
                        state_q <= IDLE;
                        proto_q <= 1'b1;
                    end else if (ctr_zero) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (setup_seen) begin
                idx_q   <= paddr[IDX_W+1:2];
                write_q <= pwrite;
                wdata_q <= pwdata;
                err_q   <= err_in;
            end

            if (wr_en) begin
                regs_q[idx_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regs
// Three completers sharing one bus driver: WAIT_CYCLES = 1, 3 and 0. A
// target selector gates psel/penable so only one instance sees a transfer.
// The reference model keeps one register array per instance and applies the
// address/error rules directly.
// -----------------------------------------------------------------------------
module tb_apb_slave_regs;

    localparam int          NREGS = 8;
    localparam logic [31:0] ID    = 32'hA5B0_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus ----------------
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [1:0]  tgt;

    logic [2:0]  psel_v, pen_v, pready_v, pslverr_v, proto_v;
    logic [31:0] prdata_v [3];

    assign psel_v = {psel && (tgt == 2'd2), psel && (tgt == 2'd1), psel && (tgt == 2'd0)};
    assign pen_v  = {penable && (tgt == 2'd2), penable && (tgt == 2'd1), penable && (tgt == 2'd0)};

    int waits [3] = '{1, 3, 0};

    apb_slave_regs #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(pen_v[0]), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0]),
        .pslverr(pslverr_v[0]), .proto_err(proto_v[0]));

    apb_slave_regs #(.WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(pen_v[1]), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1]),
        .pslverr(pslverr_v[1]), .proto_err(proto_v[1]));

    apb_slave_regs #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .psel(psel_v[2]), .penable(pen_v[2]), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready_v[2]), .prdata(prdata_v[2]),
        .pslverr(pslverr_v[2]), .proto_err(proto_v[2]));

    // ---------------- model / scoreboard ----------------
    logic [31:0] mregs [3][NREGS];
    logic        mproto [3];
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 3; t++) begin
            mproto[t] = 1'b0;
            for (int r = 0; r < NREGS; r++) mregs[t][r] = 32'h0;
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at a falling edge with the bus idle.
    task automatic apb_xfer(input logic [1:0] t, input logic wr, input logic [7:0] a,
                            input logic [31:0] d, output logic [31:0] rd, output logic er,
                            output int acc, output int done_cyc);
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        acc = 0;
        while (1) begin
            #1;
            acc++;
            if (pready_v[t]) break;
            if (acc > 40) break;
            @(negedge clk);
        end
        rd = prdata_v[t];
        er = pslverr_v[t];
        done_cyc = cyc;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_xfer(input logic [1:0] t, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, output int done_cyc);
        int          idx;
        logic        e;
        logic [31:0] exp_rd, rd;
        logic        er;
        int          acc;
        string       tag;
        idx = int'(a) / 4;
        e = (int'(a) % 4 != 0) || (idx >= NREGS) || (wr && idx == 0);
        if (e || wr)       exp_rd = 32'h0;
        else if (idx == 0) exp_rd = ID;
        else               exp_rd = mregs[t][idx];
        exp_q.push_back(exp_rd);
        apb_xfer(t, wr, a, d, rd, er, acc, done_cyc);
        tag = $sformatf("t%0d %s @%02h", t, wr ? "wr" : "rd", a);
        check_eq({tag, " pslverr"}, {31'b0, er}, {31'b0, e});
        check_eq({tag, " access_cycles"}, 32'(acc), 32'(waits[t] + 1));
        check_eq({tag, " prdata"}, rd, exp_q.pop_front());
        if (wr && !e) mregs[t][idx] = d;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: got no summary by 400000ns, required $finish earlier");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int dc, dc2;
        logic [1:0]  rt;
        logic        rw;
        logic [7:0]  ra;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; tgt = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int t = 0; t < 3; t++) begin
            check_eq($sformatf("reset t%0d pready", t), {31'b0, pready_v[t]}, 32'h0);
            check_eq($sformatf("reset t%0d prdata", t), prdata_v[t], 32'h0);
            check_eq($sformatf("reset t%0d pslverr", t), {31'b0, pslverr_v[t]}, 32'h0);
            check_eq($sformatf("reset t%0d proto_err", t), {31'b0, proto_v[t]}, 32'h0);
        end
        @(negedge clk);

        // Directed: ID read, write/read, error responses
        do_xfer(2'd0, 1'b0, 8'h00, 32'h0, dc);
        do_xfer(2'd0, 1'b1, 8'h08, 32'hDEAD_BEEF, dc);
        do_xfer(2'd0, 1'b0, 8'h08, 32'h0, dc);
        do_xfer(2'd0, 1'b0, 8'h04, 32'h0, dc);
        do_xfer(2'd0, 1'b1, 8'h00, 32'h1111_2222, dc);
        do_xfer(2'd0, 1'b0, 8'h00, 32'h0, dc);
        do_xfer(2'd0, 1'b0, 8'h20, 32'h0, dc);
        do_xfer(2'd0, 1'b0, 8'h05, 32'h0, dc);
        do_xfer(2'd0, 1'b1, 8'h1C, 32'h0BAD_F00D, dc);
        do_xfer(2'd0, 1'b0, 8'h1C, 32'h0, dc);

        // Wait-state timing: back-to-back on WAIT_CYCLES=3, pulses 5 apart
        do_xfer(2'd1, 1'b1, 8'h04, 32'h0000_00A5, dc);
        do_xfer(2'd1, 1'b0, 8'h04, 32'h0, dc2);
        check_eq("w3 back_to_back pready spacing", 32'(dc2 - dc), 32'd5);
        // WAIT_CYCLES=0: completes in the first access cycle
        do_xfer(2'd2, 1'b1, 8'h18, 32'h5A5A_0000, dc);
        do_xfer(2'd2, 1'b0, 8'h18, 32'h0, dc2);
        check_eq("w0 back_to_back pready spacing", 32'(dc2 - dc), 32'd2);

        // Randomized traffic across all three instances
        for (int n = 0; n < 80; n++) begin
            rt = 2'($urandom_range(0, 2));
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) ra = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
            else                          ra = 8'($urandom_range(0, 63));
            do_xfer(rt, rw, ra, $urandom, dc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int t = 0; t < 3; t++)
            check_eq($sformatf("after random t%0d proto_err", t), {31'b0, proto_v[t]}, {31'b0, mproto[t]});

        // Abort: drop psel mid-wait on WAIT_CYCLES=3
        do_xfer(2'd1, 1'b1, 8'h0C, 32'hCAFE_0042, dc);
        tgt = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h1234_5678;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #1;
        check_eq("abort pready mid-wait", {31'b0, pready_v[1]}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        #1;
        mproto[1] = 1'b1;
        check_eq("abort proto_err", {31'b0, proto_v[1]}, {31'b0, mproto[1]});
        @(negedge clk);
        do_xfer(2'd1, 1'b0, 8'h0C, 32'h0, dc);

        // penable without psel from IDLE on WAIT_CYCLES=1
        tgt = 2'd0; psel = 1'b0; penable = 1'b1;
        @(negedge clk);
        penable = 1'b0;
        #1;
        mproto[0] = 1'b1;
        check_eq("idle penable proto_err t0", {31'b0, proto_v[0]}, {31'b0, mproto[0]});
        check_eq("idle penable proto_err t2", {31'b0, proto_v[2]}, {31'b0, mproto[2]});
        @(negedge clk);
        do_xfer(2'd0, 1'b0, 8'h08, 32'h0, dc);

        // Reset mid-access during a write to 0x10 on WAIT_CYCLES=3
        tgt = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h7777_7777;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst-mid pready before", {31'b0, pready_v[1]}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        model_reset();
        check_eq("rst-mid pready", {31'b0, pready_v[1]}, 32'h0);
        check_eq("rst-mid prdata", prdata_v[1], 32'h0);
        check_eq("rst-mid pslverr", {31'b0, pslverr_v[1]}, 32'h0);
        check_eq("rst-mid proto_err t1", {31'b0, proto_v[1]}, 32'h0);
        check_eq("rst-mid proto_err t0", {31'b0, proto_v[0]}, 32'h0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        do_xfer(2'd1, 1'b0, 8'h10, 32'h0, dc);
        do_xfer(2'd0, 1'b0, 8'h08, 32'h0, dc);
        do_xfer(2'd1, 1'b0, 8'h00, 32'h0, dc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
